lfsr_rng_gen: RTL

LFSR_RNG_GEN -- requirements
Module: lfsr_rng_gen

---
 rtl/lfsr_rng_gen.sv | 129 ++++++++++++
 1 files changed

// File: rtl/lfsr_rng_gen.sv
// Fibonacci-style LFSR random generator.
// Free-running step mode, plus a WIDTH-advance draw handshake.
//
// Ports:
//   clk   - rising-edge clock
//   rs_n  - asynchronous active-low reset
//   load  - load seed into q and the stored seed
//   seed  - seed value
//   step  - advance q once (idle only)
//   req   - start a draw of one fresh word
//   ack   - consumer takes rnd
//   q     - current register state
//   rnd   - drawn word, held while valid
//   busy  - draw in progress
//   valid - rnd holds an unconsumed word
//   wrap  - pulse after an advance lands on the stored seed
module lfsr_rng_gen #(
  parameter int unsigned WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS =
    WIDTH'(8'b0001_1101),
  parameter bit FULL_CYCLE = 1'b1,
  parameter logic [WIDTH-1:0] RESET_SEED =
    {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic             clk,
  input  logic             rs_n,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             step,
  input  logic             req,
  input  logic             ack,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rnd,
  output logic             busy,
  output logic             valid,
  output logic             wrap
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE =
    {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] seed_r;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] q_adv;
  logic             fb;
  logic             z;
  logic             hit;

  // z injects the all-zero state in full-cycle mode;
  // in maximal mode the zero state is forced out to 1.
  always_comb begin
    fb    = ^(q & TAPS);
    z     = FULL_CYCLE && (q[WIDTH-1:1] == '0);
    q_adv = {fb ^ z, q[WIDTH-1:1]};
    if (!FULL_CYCLE && (q == '0)) begin
      q_adv = ONE;
    end
    hit = (q_adv == seed_r);
  end

  // The req edge is the first advance, RUN adds the
  // remaining WIDTH-1, and the last RUN edge captures.
  always_ff @(posedge clk or negedge rs_n) begin
    if (!rs_n) begin
      state  <= IDLE;
      q      <= RESET_SEED;
      seed_r <= RESET_SEED;
      rnd    <= '0;
      busy   <= 1'b0;
      valid  <= 1'b0;
      wrap   <= 1'b0;
      cnt    <= '0;
    end else begin
      wrap <= 1'b0;
      if (load) begin
        state  <= IDLE;
        q      <= seed;
        seed_r <= seed;
        busy   <= 1'b0;
        valid  <= 1'b0;
        cnt    <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (req) begin
              state <= RUN;
              busy  <= 1'b1;
              cnt   <= '0;
              q     <= q_adv;
              wrap  <= hit;
            end else if (step) begin
              q    <= q_adv;
              wrap <= hit;
            end
          end
          RUN: begin
            if (cnt == LAST) begin
              state <= DONE;
              rnd   <= q;
              busy  <= 1'b0;
              valid <= 1'b1;
            end else begin
              q    <= q_adv;
              wrap <= hit;
              cnt  <= cnt + CW'(1);
            end
          end
          DONE: begin
            if (ack) begin
              state <= IDLE;
              valid <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
